// File: rtl/fwd_pipeline_tracker_pkg.sv
// Shared definitions for the forwarding pipeline tracker: forwarding select
// encodings, stall FSM states and the stall counter width.
package fwd_pipeline_tracker_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        StRun,
        StStall1,
        StStall2,
        StErr
    } stall_state_e;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fwd_pipeline_tracker_dest_stage_reg.sv
// One pipeline slot of destination tracking: register specifier, write enable
// and load flag, with hold (en_i=0) and bubble-insert controls.
module dest_stage_reg #(
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          bubble_i,
    input  logic [RW-1:0] rd_i,
    input  logic          rf_le_i,
    input  logic          ld_i,
    output logic [RW-1:0] rd_o,
    output logic          rf_le_o,
    output logic          ld_o
);

    logic [RW-1:0] rd_q, rd_d;
    logic          rf_le_q, rf_le_d;
    logic          ld_q, ld_d;

    always_comb begin
        rd_d    = rd_q;
        rf_le_d = rf_le_q;
        ld_d    = ld_q;
        if (bubble_i) begin
            rd_d    = '0;
            rf_le_d = 1'b0;
            ld_d    = 1'b0;
        end else if (en_i) begin
            rd_d    = rd_i;
            // r0 is hardwired, so a write to it is never tracked
            rf_le_d = rf_le_i && (rd_i != '0);
            ld_d    = ld_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            rf_le_q <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            rf_le_q <= rf_le_d;
            ld_q    <= ld_d;
        end
    end

    assign rd_o    = rd_q;
    assign rf_le_o = rf_le_q;
    assign ld_o    = ld_q;

endmodule

// File: rtl/fwd_pipeline_tracker.sv
// Tracks destination registers through EX/MEM/WB, muxes forwarded operands and
// monitors bubble insertion with a saturating counter and excessive-stall FSM.
module fwd_pipeline_tracker
    import fwd_pipeline_tracker_pkg::*;
#(
    parameter int unsigned RW = 5,
    parameter int unsigned DW = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RW-1:0]          ID_RD,
    input  logic                   ID_RF_LE,
    input  logic                   ID_L,
    input  logic                   NOP,
    input  logic                   LE,
    input  logic [1:0]             A_S,
    input  logic [1:0]             B_S,
    input  logic [DW-1:0]          RF_A,
    input  logic [DW-1:0]          RF_B,
    input  logic [DW-1:0]          EX_RES,
    input  logic [DW-1:0]          MEM_RES,
    input  logic [DW-1:0]          WB_RES,
    input  logic                   CLR_CNT,
    output logic [RW-1:0]          EX_RD,
    output logic [RW-1:0]          MEM_RD,
    output logic [RW-1:0]          WB_RD,
    output logic                   EX_RF_LE,
    output logic                   MEM_RF_LE,
    output logic                   WB_RF_LE,
    output logic                   EX_L,
    output logic [DW-1:0]          OPA,
    output logic [DW-1:0]          OPB,
    output logic [STALL_CNT_W-1:0] STALL_CNT,
    output logic                   STALL_ERR
);

    // A bubble advances MEM/WB even while the hazard unit holds LE low
    logic advance;
    assign advance = NOP | LE;

    logic mem_ld_unused, wb_ld_unused;

    dest_stage_reg #(.RW(RW)) u_ex_stage (
        .clk      (clk),
        .reset    (reset),
        .en_i     (advance),
        .bubble_i (NOP),
        .rd_i     (ID_RD),
        .rf_le_i  (ID_RF_LE),
        .ld_i     (ID_L),
        .rd_o     (EX_RD),
        .rf_le_o  (EX_RF_LE),
        .ld_o     (EX_L)
    );

    dest_stage_reg #(.RW(RW)) u_mem_stage (
        .clk      (clk),
        .reset    (reset),
        .en_i     (advance),
        .bubble_i (1'b0),
        .rd_i     (EX_RD),
        .rf_le_i  (EX_RF_LE),
        .ld_i     (1'b0),
        .rd_o     (MEM_RD),
        .rf_le_o  (MEM_RF_LE),
        .ld_o     (mem_ld_unused)
    );

    dest_stage_reg #(.RW(RW)) u_wb_stage (
        .clk      (clk),
        .reset    (reset),
        .en_i     (advance),
        .bubble_i (1'b0),
        .rd_i     (MEM_RD),
        .rf_le_i  (MEM_RF_LE),
        .ld_i     (1'b0),
        .rd_o     (WB_RD),
        .rf_le_o  (WB_RF_LE),
        .ld_o     (wb_ld_unused)
    );

    function automatic logic [DW-1:0] fwd_sel(
        input logic [1:0]    sel,
        input logic [DW-1:0] rf,
        input logic [DW-1:0] ex,
        input logic [DW-1:0] mem,
        input logic [DW-1:0] wb
    );
        logic [DW-1:0] res;
        res = rf;
        unique case (sel)
            FWD_RF:  res = rf;
            FWD_EX:  res = ex;
            FWD_MEM: res = mem;
            FWD_WB:  res = wb;
        endcase
        return res;
    endfunction

    always_comb begin
        OPA = fwd_sel(A_S, RF_A, EX_RES, MEM_RES, WB_RES);
        OPB = fwd_sel(B_S, RF_B, EX_RES, MEM_RES, WB_RES);
    end

    stall_state_e           state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   err_set;

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        unique case (state_q)
            StRun:    if (NOP) state_d = StStall1;
            StStall1: state_d = NOP ? StStall2 : StRun;
            StStall2: begin
                state_d = NOP ? StErr : StRun;
                err_set = NOP;
            end
            StErr:    if (!NOP) state_d = StRun;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (CLR_CNT) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            if (NOP) cnt_d = sat_inc(cnt_q);
            if (err_set) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign STALL_CNT = cnt_q;
    assign STALL_ERR = err_q;

endmodule
